// File: rtl/hamming_frame_seq.sv
// Frame sequencer for a serial Hamming-distance accumulator.
// Accepts one operand pair with its threshold, clears the external
// accumulator, streams the operand bits LSB first, then captures the
// accumulated distance and threshold comparison for a downstream consumer.
module hamming_frame_seq #(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  g_word,
   input  logic [N-1:0]  e_word,
   input  logic [CW-1:0] thresh,
   output logic          g_bit,
   output logic          e_bit,
   output logic          acc_rst,
   input  logic [CW-1:0] acc_o,
   output logic [CW-1:0] dist_out,
   output logic          match,
   output logic          dist_valid,
   input  logic          dist_ready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DONE
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [N-1:0]   g_reg;
   logic [N-1:0]   e_reg;
   logic [CW-1:0]  th_reg;
   logic [IW-1:0]  idx;
   logic           last;
   logic           accept;
   logic           capture;

   assign last = (idx == IW'(N - 1));

   // State register; reset returns to IDLE from any state, aborting a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and output decode; rst gates every handshake/serial output
   // combinationally so nothing leaks during the reset cycle itself.
   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      acc_rst    = rst;
      g_bit      = 1'b0;
      e_bit      = 1'b0;
      dist_valid = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid && !rst) begin
               accept   = 1'b1;
               state_nx = CLEAR;
            end
         end
         CLEAR: begin
            acc_rst  = 1'b1;
            state_nx = SHIFT;
         end
         SHIFT: begin
            g_bit = ~rst & g_reg[idx];
            e_bit = ~rst & e_reg[idx];
            if (last) begin
               capture  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            dist_valid = ~rst;
            if (dist_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Operand capture, bit index and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         dist_out <= '0;
         match    <= 1'b0;
      end else begin
         if (accept) begin
            g_reg  <= g_word;
            e_reg  <= e_word;
            th_reg <= thresh;
         end
         if (state == SHIFT) begin
            idx <= last ? '0 : idx + IW'(1);
         end
         if (capture) begin
            dist_out <= acc_o;
            match    <= (acc_o <= th_reg);
         end
      end
   end

endmodule

// File: doc/hamming_frame_seq.md
HAMMING_FRAME_SEQ -- requirements
Module: hamming_frame_seq

Interface
REQ-001 SHALL have parameter N, default 32, giving bits per frame (the serial Hamming accumulator's cycle count).
REQ-002 SHALL have parameter CW, default 6, giving the count width, equal to clog2(N)+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a frame word pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a frame.
REQ-007 SHALL have port g_word, input, N bits: garbler operand.
REQ-008 SHALL have port e_word, input, N bits: evaluator operand.
REQ-009 SHALL have port thresh, input, CW bits: match threshold, captured with the frame.
REQ-010 SHALL have port g_bit, output, 1 bit: serial garbler bit to the accumulator's g_input.
REQ-011 SHALL have port e_bit, output, 1 bit: serial evaluator bit to the accumulator's e_input.
REQ-012 SHALL have port acc_rst, output, 1 bit: drives the accumulator's rst.
REQ-013 SHALL have port acc_o, input, CW bits: the accumulator's combinational sum output o.
REQ-014 SHALL have port dist_out, output, CW bits: captured Hamming distance.
REQ-015 SHALL have port match, output, 1 bit: 1 when dist_out <= captured thresh.
REQ-016 SHALL have port dist_valid, output, 1 bit: result available.
REQ-017 SHALL have port dist_ready, input, 1 bit: downstream accepts the result.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, CLEAR, SHIFT, DONE.
REQ-019 SHALL assert in_ready only in IDLE; a frame is accepted on an edge where in_valid and in_ready are both 1.
REQ-020 On acceptance, SHALL load g_word, e_word and thresh into internal registers and move IDLE->CLEAR.
REQ-021 SHALL assert acc_rst for exactly the one CLEAR cycle, then move CLEAR->SHIFT with bit index 0.
REQ-022 In SHIFT, SHALL drive g_bit/e_bit from the registered words' bit [index], LSB first.
REQ-023 In SHIFT, SHALL advance the index by 1 per cycle.
REQ-024 Outside SHIFT, SHALL drive g_bit = e_bit = 0, so the accumulator adds nothing.
REQ-025 In the SHIFT cycle with index N-1, SHALL capture acc_o into dist_out and compute match from acc_o <= thresh (unsigned); on that edge it SHALL move to DONE.
REQ-026 SHALL assert dist_valid in DONE only; the first dist_valid cycle follows the accepting edge by N+1 edges (33 for N=32).
REQ-027 SHALL hold dist_out and match stable while dist_valid=1 and dist_ready=0.
REQ-028 On dist_valid and dist_ready both 1, SHALL move DONE->IDLE; the next frame can be accepted no earlier than the following edge.
REQ-029 SHALL ignore in_valid, and leave words unchanged, in CLEAR, SHIFT and DONE.
REQ-030 SHALL hold dist_out and match at their last captured values outside DONE.
REQ-031 The index counter SHALL be clog2(N) bits, and SHALL NOT wrap inside a frame.
REQ-032 SHALL produce results for all-equal operands (distance 0) and for all-different operands (distance N=32, needing the full CW=6 bits) without overflow.

Reset
REQ-033 While rst=1, SHALL force state to IDLE, index to 0, and dist_out, match, dist_valid, g_bit and e_bit to 0.
REQ-034 While rst=1, SHALL drive acc_rst=1.
REQ-035 While rst=1, SHALL drive in_ready=0.
REQ-036 rst asserted in any state mid-frame SHALL abort the frame with no dist_valid pulse; the first accept is possible on the first edge after rst deasserts.

Verification
REQ-037 g_word=0xFFFF0000, e_word=0x0000FFFF, thresh=40 -> dist_valid 33 edges after accept, dist_out=32, match=1.
REQ-038 g_word=e_word=0xA5A5A5A5, thresh=0 -> dist_out=0, match=1; g_bit/e_bit sequence 1,0,1,0,0,1,0,1,...
REQ-039 g_word=0x00000001, e_word=0, thresh=0 -> dist_out=1, match=0.
REQ-040 dist_ready held 0 for 10 cycles after dist_valid -> outputs stable; in_valid=1 throughout, with in_ready=0 until the DONE->IDLE edge.
REQ-041 Back-to-back frames 0xFFFFFFFF/0 then 0x0000000F/0 -> second dist_out=4; acc_rst pulses once per frame, so there is no carry-over from the first frame.
REQ-042 rst pulsed at SHIFT index 17 -> no dist_valid; the next frame 0x3/0x0 yields dist_out=2.
